// File: rtl/vote_booth_scheduler_if.sv
// Booth/datapath bundle for vote_booth_scheduler.
// master: booth/session side; slave: the scheduler.
interface vote_booth_scheduler_if #(
   parameter int NUM_BOOTHS = 4,
   parameter int COUNT_W    = 8
);
   logic                    start;
   logic                    close;
   logic [NUM_BOOTHS-1:0]   booth_req;
   logic [4*NUM_BOOTHS-1:0] booth_choice;
   logic [NUM_BOOTHS-1:0]   booth_grant;
   logic [NUM_BOOTHS-1:0]   booth_ack;
   logic [NUM_BOOTHS-1:0]   booth_nack;
   logic [3:0]              dp_voter;
   logic                    dp_confirm;
   logic [1:0]              dp_mode;
   logic [COUNT_W-1:0]      vote_count;
   logic [1:0]              phase;

   modport master (
      output start, close, booth_req, booth_choice,
      input  booth_grant, booth_ack, booth_nack,
      input  dp_voter, dp_confirm, dp_mode,
      input  vote_count, phase
   );

   modport slave (
      input  start, close, booth_req, booth_choice,
      output booth_grant, booth_ack, booth_nack,
      output dp_voter, dp_confirm, dp_mode,
      output vote_count, phase
   );
endinterface

// File: rtl/vote_booth_scheduler.sv
// Session FSM + round-robin arbiter sharing one vote datapath.
// Ports: clk, rst (async high), bus (slave: start/close/booth_req/
//   booth_choice in; booth_grant/ack/nack, dp_voter/confirm/mode,
//   vote_count, phase out). Option macro: BOOTH_LOCKOUT_EN.
module vote_booth_scheduler #(
   parameter int NUM_BOOTHS   = 4,
   parameter int MAX_VOTES    = 255,
   parameter int COUNT_W      = 8,
   parameter int CLEAR_CYCLES = 2
) (
   input logic                   clk,
   input logic                   rst,
   vote_booth_scheduler_if.slave bus
);
   localparam int IDX_W = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
   localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
   localparam logic [CLR_W-1:0]   CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
   localparam logic [COUNT_W-1:0] MAX_C    = COUNT_W'(MAX_VOTES);
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_BOOTHS - 1);
   localparam logic [NUM_BOOTHS-1:0] ONE   = NUM_BOOTHS'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_OPEN, S_SETUP,
      S_PULSE, S_GAP, S_CLOSED
   } state_t;

   state_t                  state_q;
   logic [IDX_W-1:0]        ptr_q;
   logic [IDX_W-1:0]        sel_q;
   logic [3:0]              choice_q;
   logic [CLR_W-1:0]        clr_cnt_q;
   logic                    close_pend_q;
   logic [NUM_BOOTHS-1:0]   grant_q;
   logic [NUM_BOOTHS-1:0]   ack_q;
   logic [NUM_BOOTHS-1:0]   nack_q;
   logic [3:0]              voter_q;
   logic                    confirm_q;
   logic [1:0]              mode_q;
   logic [COUNT_W-1:0]      count_q;
   logic [1:0]              phase_q;
`ifdef BOOTH_LOCKOUT_EN
   logic [NUM_BOOTHS-1:0]   voted_q;
`endif

   logic [NUM_BOOTHS-1:0]   req_m;
   logic                    arb_hit;
   logic [IDX_W-1:0]        arb_idx;
   logic [3:0]              arb_choice;
   logic                    arb_bad;
   logic [COUNT_W-1:0]      count_d;
   logic                    hit_max;

   function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
      return (i == IDX_LAST) ? '0 : i + 1'b1;
   endfunction

   // A booth sees its ack/nack while its req is still high;
   // mask it that cycle so it is not re-arbitrated.
   assign req_m = bus.booth_req & ~(ack_q | nack_q);

   // Pass 1: lowest requester overall (wrap case).
   // Pass 2: lowest requester at/after ptr overrides it.
   always_comb begin
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int i = NUM_BOOTHS - 1; i >= 0; i--) begin
         if (req_m[i]) begin
            arb_hit = 1'b1;
            arb_idx = IDX_W'(i);
         end
      end
      for (int i = NUM_BOOTHS - 1; i >= 0; i--) begin
         if (req_m[i] && (IDX_W'(i) >= ptr_q)) arb_idx = IDX_W'(i);
      end
   end

   assign arb_choice = bus.booth_choice[4*arb_idx +: 4];

   always_comb begin
      arb_bad = (arb_choice == 4'd0) ||
                ((arb_choice & (arb_choice - 4'd1)) != 4'd0);
`ifdef BOOTH_LOCKOUT_EN
      if (voted_q[arb_idx]) arb_bad = 1'b1;
`endif
   end

   assign count_d = (count_q == MAX_C) ? count_q : count_q + 1'b1;
   assign hit_max = (count_d == MAX_C);

   // Outputs are set on entry to a state, so they lag the state by
   // one cycle: grant shows in SETUP, voter in PULSE, confirm in GAP,
   // ack/count in the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ptr_q        <= '0;
         sel_q        <= '0;
         choice_q     <= '0;
         clr_cnt_q    <= '0;
         close_pend_q <= 1'b0;
         grant_q      <= '0;
         ack_q        <= '0;
         nack_q       <= '0;
         voter_q      <= '0;
         confirm_q    <= 1'b0;
         mode_q       <= 2'b11;
         count_q      <= '0;
         phase_q      <= 2'b00;
`ifdef BOOTH_LOCKOUT_EN
         voted_q      <= '0;
`endif
      end else begin
         ack_q  <= '0;
         nack_q <= '0;
         unique case (state_q)
            S_IDLE, S_CLOSED: begin
               grant_q <= '0;
               if (bus.start) begin
                  state_q      <= S_CLEAR;
                  mode_q       <= 2'b10;
                  phase_q      <= 2'b01;
                  clr_cnt_q    <= '0;
                  count_q      <= '0;
                  ptr_q        <= '0;
                  close_pend_q <= 1'b0;
                  voter_q      <= '0;
`ifdef BOOTH_LOCKOUT_EN
                  voted_q      <= '0;
`endif
               end
            end
            S_CLEAR: begin
               if (clr_cnt_q == CLR_LAST) begin
                  state_q <= S_OPEN;
                  mode_q  <= 2'b00;
                  phase_q <= 2'b10;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            S_OPEN: begin
               grant_q <= '0;
               if (bus.close) begin
                  state_q <= S_CLOSED;
                  mode_q  <= 2'b01;
                  phase_q <= 2'b11;
                  voter_q <= '0;
               end else if (arb_hit) begin
                  if (arb_bad) begin
                     nack_q <= ONE << arb_idx;
                     ptr_q  <= nxt(arb_idx);
                  end else begin
                     grant_q  <= ONE << arb_idx;
                     sel_q    <= arb_idx;
                     choice_q <= arb_choice;
                     state_q  <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               voter_q <= choice_q;
               state_q <= S_PULSE;
               if (bus.close) close_pend_q <= 1'b1;
            end
            S_PULSE: begin
               confirm_q <= 1'b1;
               state_q   <= S_GAP;
               if (bus.close) close_pend_q <= 1'b1;
            end
            S_GAP: begin
               confirm_q <= 1'b0;
               ack_q     <= ONE << sel_q;
               count_q   <= count_d;
               ptr_q     <= nxt(sel_q);
`ifdef BOOTH_LOCKOUT_EN
               voted_q[sel_q] <= 1'b1;
`endif
               if (close_pend_q || bus.close || hit_max) begin
                  state_q      <= S_CLOSED;
                  mode_q       <= 2'b01;
                  phase_q      <= 2'b11;
                  voter_q      <= '0;
                  close_pend_q <= 1'b0;
               end else begin
                  state_q <= S_OPEN;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.booth_grant = grant_q;
   assign bus.booth_ack   = ack_q;
   assign bus.booth_nack  = nack_q;
   assign bus.dp_voter    = voter_q;
   assign bus.dp_confirm  = confirm_q;
   assign bus.dp_mode     = mode_q;
   assign bus.vote_count  = count_q;
   assign bus.phase       = phase_q;
endmodule

// File: tb/tb_vote_booth_scheduler.sv
// Directed bench for vote_booth_scheduler (default and MAX_VOTES=3).
// Expected values are hand-derived cycle by cycle.
module tb_vote_booth_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        close = 1'b0;
   logic        sel = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] choice = 16'h8421;
   int          n_run = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   vote_booth_scheduler_if bus ();
   vote_booth_scheduler_if bus3 ();

   assign bus.start         = start & ~sel;
   assign bus.close         = close & ~sel;
   assign bus.booth_req     = sel ? 4'b0 : req;
   assign bus.booth_choice  = choice;
   assign bus3.start        = start & sel;
   assign bus3.close        = close & sel;
   assign bus3.booth_req    = sel ? req : 4'b0;
   assign bus3.booth_choice = choice;

   vote_booth_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   vote_booth_scheduler #(.MAX_VOTES(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   logic [3:0] og, oa, on, ov;
   logic       oc;
   logic [1:0] om, op;
   logic [7:0] ocnt;

   assign og   = sel ? bus3.booth_grant : bus.booth_grant;
   assign oa   = sel ? bus3.booth_ack   : bus.booth_ack;
   assign on   = sel ? bus3.booth_nack  : bus.booth_nack;
   assign ov   = sel ? bus3.dp_voter    : bus.dp_voter;
   assign oc   = sel ? bus3.dp_confirm  : bus.dp_confirm;
   assign om   = sel ? bus3.dp_mode     : bus.dp_mode;
   assign op   = sel ? bus3.phase       : bus.phase;
   assign ocnt = sel ? bus3.vote_count  : bus.vote_count;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called in the cycle the grant should be visible; returns in the
   // ack cycle.
   task automatic vote(input int b, input int cnt);
      chk("grant", 32'(og), 32'(1 << b));
      step();
      chk("voter", 32'(ov), 32'(1 << b));
      chk("conf_lo", 32'(oc), 0);
      step();
      chk("conf_hi", 32'(oc), 1);
      step();
      chk("ack", 32'(oa), 32'(1 << b));
      chk("count", 32'(ocnt), 32'(cnt));
      chk("conf_off", 32'(oc), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "timeout");
   end

   initial begin
      step();
      step();
      chk("rst_phase", 32'(op), 0);
      chk("rst_mode", 32'(om), 3);
      chk("rst_grant", 32'(og), 0);
      chk("rst_count", 32'(ocnt), 0);
      chk("rst_conf", 32'(oc), 0);
      chk("rst_voter", 32'(ov), 0);
      rst = 1'b0;
      close = 1'b1;
      step();
      close = 1'b0;
      chk("idle_close", 32'(op), 0);

      start = 1'b1;
      step();
      start = 1'b0;
      chk("clr1_phase", 32'(op), 1);
      chk("clr1_mode", 32'(om), 2);
      step();
      chk("clr2_phase", 32'(op), 1);
      chk("clr2_mode", 32'(om), 2);
      step();
      chk("open_phase", 32'(op), 2);
      chk("open_mode", 32'(om), 0);
      chk("open_count", 32'(ocnt), 0);

      // all four booths, round robin 0,1,2,3,0
      req = 4'b1111;
      step();
      for (int k = 0; k < 5; k++) begin
         vote(k % 4, k + 1);
         if (k == 4) req = 4'b0;
         step();
      end
      chk("rr_idle", 32'(og), 0);

      // booth 2 alone
      req = 4'b0100;
      step();
      vote(2, 6);
      req = 4'b0;
      step();
      chk("b2_gdrop", 32'(og), 0);
      chk("b2_adrop", 32'(oa), 0);

      // invalid choice from booth 1, booth 2 also waiting
      choice[7:4] = 4'b0110;
      req = 4'b0110;
      step();
      chk("nack", 32'(on), 32'h2);
      chk("nack_grant", 32'(og), 0);
      chk("nack_conf", 32'(oc), 0);
      chk("nack_count", 32'(ocnt), 6);
      step();
      req = 4'b0100;
      vote(2, 7);
      req = 4'b0;
      choice[7:4] = 4'b0010;
      step();

      // close pulse while the vote is in flight
      req = 4'b0001;
      step();
      chk("cl_grant", 32'(og), 1);
      step();
      close = 1'b1;
      step();
      close = 1'b0;
      chk("cl_conf", 32'(oc), 1);
      step();
      chk("cl_ack", 32'(oa), 1);
      chk("cl_count", 32'(ocnt), 8);
      chk("cl_phase", 32'(op), 3);
      chk("cl_mode", 32'(om), 1);
      req = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("closed_ack", 32'(oa), 0);
         chk("closed_nack", 32'(on), 0);
      end
      chk("closed_voter", 32'(ov), 0);
      chk("closed_count", 32'(ocnt), 8);
      req = 4'b0;

      // start+close in CLOSED: start wins
      start = 1'b1;
      close = 1'b1;
      step();
      start = 1'b0;
      close = 1'b0;
      chk("sc_phase", 32'(op), 1);
      chk("sc_count", 32'(ocnt), 0);
      step();
      step();
      chk("sc_open", 32'(op), 2);
      start = 1'b1;
      step();
      chk("start_open", 32'(op), 2);
      close = 1'b1;
      step();
      start = 1'b0;
      close = 1'b0;
      chk("sc_open_close", 32'(op), 3);

      // MAX_VOTES=3 instance
      sel = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("m3_open", 32'(op), 2);
      req = 4'b0001;
      step();
      vote(0, 1);
      req = 4'b0;
      step();
      req = 4'b0001;
      step();
`ifdef BOOTH_LOCKOUT_EN
      chk("lock_nack", 32'(on), 1);
      chk("lock_count", 32'(ocnt), 1);
      req = 4'b0;
      step();
      req = 4'b0110;
      step();
      vote(1, 2);
      step();
      vote(2, 3);
`else
      vote(0, 2);
      req = 4'b0110;
      step();
      vote(1, 3);
`endif
      chk("m3_closed", 32'(op), 3);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("m3_ack", 32'(oa), 0);
         chk("m3_nack", 32'(on), 0);
         chk("m3_sat", 32'(ocnt), 3);
      end
      req = 4'b0;
      sel = 1'b0;

      // reset in the middle of a vote
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      req = 4'b0001;
      step();
      step();
      step();
      chk("mid_conf", 32'(oc), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_conf", 32'(oc), 0);
      chk("mid_rst_phase", 32'(op), 0);
      chk("mid_rst_grant", 32'(og), 0);
      chk("mid_rst_count", 32'(ocnt), 0);
      chk("mid_rst_mode", 32'(om), 3);
      req = 4'b0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule

// File: doc/vote_booth_scheduler.md
Name: vote_booth_scheduler

Overview:
- Session controller and round-robin arbiter that lets NUM_BOOTHS voting booths share the single 4-candidate vote-counting datapath.
- Drives the datapath's voter, confirm and mode inputs. Runs the session lifecycle: clear, open, vote, close/count.
- Produces confirm as a clean rising edge per accepted vote, because the datapath counts on confirm rising edges.

Parameters:
- NUM_BOOTHS, 4, number of requesting booths (2..8).
- MAX_VOTES, 255, accepted votes per session; reaching it auto-closes the session.
- COUNT_W, 8, width of vote_count; must hold MAX_VOTES.
- CLEAR_CYCLES, 2, cycles dp_mode is held at 2'b10 to clear the counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level; begin a new session (clear then open)
- close  in  1  level; end voting, enter counting
- booth_req  in  NUM_BOOTHS  per-booth vote request, held until ack/nack
- booth_choice  in  4*NUM_BOOTHS  per-booth candidate, one-hot; booth i uses bits [4i+3:4i]
- booth_grant  out  NUM_BOOTHS  one-hot; booth currently being serviced
- booth_ack  out  NUM_BOOTHS  1-cycle pulse; vote accepted
- booth_nack  out  NUM_BOOTHS  1-cycle pulse; vote rejected
- dp_voter  out  4  to datapath voter
- dp_confirm  out  1  to datapath confirm
- dp_mode  out  2  to datapath mode (00 vote, 01 count, 10 clear, 11 idle)
- vote_count  out  COUNT_W  accepted votes this session
- phase  out  2  00 IDLE, 01 CLEARING, 10 OPEN, 11 CLOSED

Behaviour:
- Reset values (asynchronous): state IDLE, dp_mode=11, dp_voter=0, dp_confirm=0, grant/ack/nack=0, vote_count=0, RR pointer=0.
- All outputs are registered.

State machine:
- IDLE: start -> CLEAR.
- CLEAR: dp_mode=10 for CLEAR_CYCLES cycles. Clears vote_count and pointer. Then -> OPEN.
- OPEN: dp_mode=00. Arbitrate among booth_req, round-robin starting at the pointer; the lowest index at or after the pointer wins.
  - Non-one-hot choice: nack the winner the next cycle, advance the pointer, stay in OPEN, no datapath activity.
  - Valid choice: grant -> SETUP.
- SETUP: dp_voter=choice, dp_confirm=0, grant held.
- PULSE: dp_confirm=1, dp_voter held.
- GAP: dp_confirm=0, dp_voter held. Ack pulses this cycle; vote_count increments; pointer = granted index + 1 mod NUM_BOOTHS; grant drops next cycle. Then -> OPEN, or -> CLOSED if close is pending or vote_count reaches MAX_VOTES.
- Each accepted vote occupies exactly 4 cycles: grant cycle, SETUP, PULSE, GAP. dp_confirm is low for at least 3 cycles between pulses.
- CLOSED: dp_mode=01, dp_voter=0; all requests ignored, no ack/nack. start -> CLEAR.

Boundary conditions:
- close during SETUP/PULSE/GAP: latched; the vote in flight completes and is counted, then CLOSED.
- start and close together: in OPEN, close wins; in IDLE/CLOSED, start wins (close ignored).
- start while OPEN: ignored.
- close in IDLE: ignored.
- vote_count saturates at MAX_VOTES and never wraps.
- Requests in IDLE, CLEAR or CLOSED are neither acked nor nacked; they stay pending.
- A booth that drops booth_req after grant still completes its vote.
- rst asserted mid-vote: everything returns to reset values immediately. dp_confirm falls without a counted edge.

Optional Feature:
- BOOTH_LOCKOUT_EN defined: a per-booth voted flag is set on ack and cleared in CLEAR.
  - A locked booth requesting in OPEN is nacked via the same path as an invalid choice.
  - Enforces one vote per booth per session.
- Not defined: booths may vote any number of times.

Test Plan:
- Reset, start -> phase 01 for 2 cycles with dp_mode=10, then phase 10 with dp_mode=00 and vote_count=0.
- Booth 2 requests choice 4'b0100 -> grant=0100 at cycle t, dp_voter=0100 at t+1, dp_confirm=1 only at t+2, ack[2] pulse at t+3, vote_count=1.
- All 4 booths request continuously with valid choices -> grants in order 0,1,2,3,0, each 4 cycles apart; 5 acks.
- Booth 1 choice 4'b0110 -> nack[1] pulse, dp_confirm stays 0, vote_count unchanged; the next grant goes to booth 2 when booths 1 and 2 both request.
- close asserted during PULSE -> ack still issued, vote_count incremented, then phase 11 with dp_mode=01; later requests get no ack or nack.
- MAX_VOTES=3 -> after the 3rd ack, auto CLOSED. With BOOTH_LOCKOUT_EN, a second request from booth 0 -> nack[0] and no count change.
